// File: rtl/clk_divider_prog.sv
// clk_divider_prog
//   N_CH independent divided clocks, all derived from clk_in. Each channel
//   produces a 50%-duty divided_clk and a one-cycle tick in the cycle that
//   divided_clk toggles. The half-period of a channel is active_div+1 cycles.
//   A divisor is reloaded through a single config port and takes effect at a
//   toggle boundary, so a half-period never changes length partway through.
//
// Ports
//   clk_in       system clock
//   rst_n        asynchronous active-low reset
//   en[N_CH]     per-channel run enable; a disabled channel holds cnt/output
//   cfg_valid    config write request
//   cfg_ch       target channel (values >= N_CH are accepted and dropped)
//   cfg_div      new toggle value for the target channel
//   cfg_ready    config write can be accepted this cycle (combinational)
//   divided_clk  per-channel divided clock (registered)
//   tick         per-channel toggle strobe (registered)
//
// Config handshake: a write transfers on a rising clk_in edge where
// cfg_valid && cfg_ready. cfg_ready depends only on cfg_ch and on the
// target channel's pending flag; it never depends on cfg_valid. Each
// channel has one pending slot, so a second write to a channel whose slot
// is full is stalled (cfg_ready low) until that slot drains.
module clk_divider_prog #(
  parameter int N_CH           = 2,
  parameter int CNT_W          = 25,
  parameter int DEFAULT_TOGGLE = 1000000,
  parameter int CH_W           = 3
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   en,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [N_CH-1:0]   divided_clk,
  output logic [N_CH-1:0]   tick
);

  logic [CNT_W-1:0] cnt_q        [N_CH];
  logic [CNT_W-1:0] cnt_d        [N_CH];
  logic [CNT_W-1:0] active_div_q [N_CH];
  logic [CNT_W-1:0] active_div_d [N_CH];
  logic [CNT_W-1:0] shadow_div_q [N_CH];
  logic [CNT_W-1:0] shadow_div_d [N_CH];
  logic [N_CH-1:0]  pending_q, pending_d;
  logic [N_CH-1:0]  div_clk_q, div_clk_d;
  logic [N_CH-1:0]  tick_q, tick_d;
  logic [N_CH-1:0]  cfg_hit;   // an accepted write targets this channel

  // Out-of-range channels never match, so cfg_ready stays at its default 1.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pending_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      cfg_hit[i] = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    active_div_d = active_div_q;
    shadow_div_d = shadow_div_q;
    pending_d    = pending_q;
    div_clk_d    = div_clk_q;
    tick_d       = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (en[i]) begin
        // >= rather than == so a counter that somehow overshot the divisor
        // still wraps here instead of running on to 2^CNT_W.
        if (cnt_q[i] >= active_div_q[i]) begin
          cnt_d[i]     = '0;
          div_clk_d[i] = ~div_clk_q[i];
          tick_d[i]    = 1'b1;
          if (pending_q[i]) begin
            active_div_d[i] = shadow_div_q[i];
            pending_d[i]    = 1'b0;
          end
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (pending_q[i]) begin
        // Idle channel: no boundary will come, so load now and restart
        // the half-period from zero. divided_clk keeps its level.
        active_div_d[i] = shadow_div_q[i];
        pending_d[i]    = 1'b0;
        cnt_d[i]        = '0;
      end
      // Acceptance requires pending_q low, so this never collides with the
      // clears above; a write landing on a terminal count waits for the
      // next boundary because the swap above used the old pending_q.
      if (cfg_hit[i]) begin
        shadow_div_d[i] = cfg_div;
        pending_d[i]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]        <= '0;
        active_div_q[i] <= CNT_W'(DEFAULT_TOGGLE);
        shadow_div_q[i] <= '0;
      end
      pending_q <= '0;
      div_clk_q <= '0;
      tick_q    <= '0;
    end else begin
      cnt_q        <= cnt_d;
      active_div_q <= active_div_d;
      shadow_div_q <= shadow_div_d;
      pending_q    <= pending_d;
      div_clk_q    <= div_clk_d;
      tick_q       <= tick_d;
    end
  end

  assign divided_clk = div_clk_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog with N_CH=2, CNT_W=6, DEFAULT_TOGGLE=3, CH_W=2.
module tb_clk_divider_prog;
  localparam int N_CH  = 2;
  localparam int CNT_W = 6;
  localparam int DEF   = 3;
  localparam int CH_W  = 2;

  logic              clk_in = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_CH-1:0]   en = '0;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic              cfg_ready;
  logic [N_CH-1:0]   divided_clk;
  logic [N_CH-1:0]   tick;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  clk_divider_prog #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEFAULT_TOGGLE(DEF), .CH_W(CH_W)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .divided_clk(divided_clk), .tick(tick)
  );

  // ---------------- reference model ----------------
  // Each channel is described by the length of its current half-period and
  // how many enabled cycles of it have elapsed; a new divisor is held in a
  // single slot and becomes the next half-period length.
  int m_half    [N_CH];
  int m_elapsed [N_CH];
  bit m_clk     [N_CH];
  bit m_tick    [N_CH];
  bit m_has     [N_CH];
  int m_new     [N_CH];

  always @(posedge clk_in or negedge rst_n) begin
    bit take;
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        m_half[c] = DEF + 1; m_elapsed[c] = 0; m_clk[c] = 0;
        m_tick[c] = 0; m_has[c] = 0; m_new[c] = 0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        take = cfg_valid && (int'(cfg_ch) == c) && !m_has[c];
        m_tick[c] = 0;
        if (en[c]) begin
          m_elapsed[c] = m_elapsed[c] + 1;
          if (m_elapsed[c] >= m_half[c]) begin
            m_elapsed[c] = 0;
            m_clk[c] = !m_clk[c];
            m_tick[c] = 1;
            if (m_has[c]) begin m_half[c] = m_new[c] + 1; m_has[c] = 0; end
          end
        end else if (m_has[c]) begin
          m_half[c] = m_new[c] + 1; m_has[c] = 0; m_elapsed[c] = 0;
        end
        if (take) begin m_has[c] = 1; m_new[c] = int'(cfg_div); end
      end
    end
  end

  function automatic logic [N_CH-1:0] exp_clk();
    logic [N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++) r[c] = m_clk[c];
    return r;
  endfunction

  function automatic logic [N_CH-1:0] exp_tick();
    logic [N_CH-1:0] r;
    for (int c = 0; c < N_CH; c++) r[c] = m_tick[c];
    return r;
  endfunction

  function automatic logic exp_ready();
    logic r;
    r = 1'b1;
    for (int c = 0; c < N_CH; c++) if (int'(cfg_ch) == c) r = !m_has[c];
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0; en = 2'b11; cfg_valid = 1; cfg_ch = 0; cfg_div = 6'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_in);
      n_tests++;
      if (divided_clk !== 2'b00 || tick !== 2'b00 || cfg_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_state clk=%b tick=%b ready=%b need 00 00 1", divided_clk, tick, cfg_ready);
      end
    end
    cfg_valid = 0; rst_n = 1;
  endtask

  task automatic test_default_run();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      n_tests++;
      if (tick !== ((k % 4 == 0) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL default_tick k=%0d got %b need %b", k, tick, (k % 4 == 0) ? 2'b11 : 2'b00);
      end
      n_tests++;
      if (divided_clk !== exp_clk() || tick !== exp_tick()) begin
        n_fail++;
        $display("FAIL default_model k=%0d clk=%b tick=%b need clk=%b tick=%b", k, divided_clk, tick, exp_clk(), exp_tick());
      end
    end
  endtask

  task automatic test_reload();
    bit ok;
    bit want_rdy;
    ok = 0;
    for (int w = 0; w < 40 && !ok; w++) begin @(negedge clk_in); if (tick[0]) ok = 1; end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL reload_sync got no tick need tick within 40 cycles"); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk_in);
      n_tests++;
      if (tick[0] !== (k == 4 || k == 6 || k == 8 || k == 10)) begin
        n_fail++; $display("FAIL reload_tick k=%0d got %b need %b", k, tick[0], (k == 4 || k == 6 || k == 8 || k == 10));
      end
      n_tests++;
      if (divided_clk !== exp_clk() || tick !== exp_tick()) begin
        n_fail++; $display("FAIL reload_model k=%0d clk=%b tick=%b need clk=%b tick=%b", k, divided_clk, tick, exp_clk(), exp_tick());
      end
      if (k == 1) begin cfg_valid = 1; cfg_ch = 0; cfg_div = 6'd1; end
      if (k == 2) cfg_valid = 0;
      #1;
      want_rdy = !(k == 2 || k == 3);
      n_tests++;
      if (cfg_ready !== want_rdy || cfg_ready !== exp_ready()) begin
        n_fail++; $display("FAIL reload_ready k=%0d got %b need %b", k, cfg_ready, want_rdy);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit want_tick;
    bit want_rdy;
    ok = 0;
    for (int w = 0; w < 40 && !ok; w++) begin @(negedge clk_in); if (tick[1]) ok = 1; end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL b2b_sync got no tick need tick within 40 cycles"); end
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk_in);
      want_tick = (k == 4 || k == 10 || k == 18 || k == 26);
      n_tests++;
      if (tick[1] !== want_tick) begin
        n_fail++; $display("FAIL b2b_tick k=%0d got %b need %b", k, tick[1], want_tick);
      end
      n_tests++;
      if (divided_clk !== exp_clk() || tick !== exp_tick()) begin
        n_fail++; $display("FAIL b2b_model k=%0d clk=%b tick=%b need clk=%b tick=%b", k, divided_clk, tick, exp_clk(), exp_tick());
      end
      if (k == 1) begin cfg_valid = 1; cfg_ch = 1; cfg_div = 6'd5; end
      if (k == 2) cfg_div = 6'd7;
      if (k == 5) cfg_valid = 0;
      #1;
      want_rdy = (k == 1 || k == 4 || k >= 10);
      n_tests++;
      if (cfg_ready !== want_rdy || cfg_ready !== exp_ready()) begin
        n_fail++; $display("FAIL b2b_ready k=%0d got %b need %b", k, cfg_ready, want_rdy);
      end
    end
  endtask

  task automatic test_collision();
    bit ok;
    bit want_tick;
    bit want_rdy;
    ok = 0;
    for (int w = 0; w < 20 && !ok; w++) begin @(negedge clk_in); if (tick[0]) ok = 1; end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL coll_sync got no tick need tick within 20 cycles"); end
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk_in);
      want_tick = (k == 2 || k == 4 || k == 9 || k == 14);
      n_tests++;
      if (tick[0] !== want_tick) begin
        n_fail++; $display("FAIL coll_tick k=%0d got %b need %b", k, tick[0], want_tick);
      end
      n_tests++;
      if (divided_clk !== exp_clk() || tick !== exp_tick()) begin
        n_fail++; $display("FAIL coll_model k=%0d clk=%b tick=%b need clk=%b tick=%b", k, divided_clk, tick, exp_clk(), exp_tick());
      end
      if (k == 1) begin cfg_valid = 1; cfg_ch = 0; cfg_div = 6'd4; end
      if (k == 2) cfg_valid = 0;
      #1;
      want_rdy = !(k == 2 || k == 3);
      n_tests++;
      if (cfg_ready !== want_rdy || cfg_ready !== exp_ready()) begin
        n_fail++; $display("FAIL coll_ready k=%0d got %b need %b", k, cfg_ready, want_rdy);
      end
    end
  endtask

  task automatic test_enable();
    bit ok;
    bit want_tick;
    bit want_rdy;
    ok = 0;
    for (int w = 0; w < 40 && !ok; w++) begin
      @(negedge clk_in); if (tick[1] && divided_clk[1]) ok = 1;
    end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL en_sync got no rising toggle need one within 40 cycles"); end
    cfg_ch = 1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_in);
      want_tick = (k == 18 || k == 27 || k == 30);
      n_tests++;
      if (tick[1] !== want_tick) begin
        n_fail++; $display("FAIL en_tick k=%0d got %b need %b", k, tick[1], want_tick);
      end
      if (k <= 12) begin
        n_tests++;
        if (divided_clk[1] !== 1'b1) begin
          n_fail++; $display("FAIL en_hold k=%0d got %b need 1", k, divided_clk[1]);
        end
      end
      n_tests++;
      if (divided_clk !== exp_clk() || tick !== exp_tick()) begin
        n_fail++; $display("FAIL en_model k=%0d clk=%b tick=%b need clk=%b tick=%b", k, divided_clk, tick, exp_clk(), exp_tick());
      end
      if (k == 2)  en = 2'b01;
      if (k == 12) en = 2'b11;
      if (k == 20) begin en = 2'b01; cfg_valid = 1; cfg_ch = 1; cfg_div = 6'd2; end
      if (k == 21) cfg_valid = 0;
      if (k == 24) en = 2'b11;
      #1;
      want_rdy = (k != 21);
      n_tests++;
      if (cfg_ready !== want_rdy || cfg_ready !== exp_ready()) begin
        n_fail++; $display("FAIL en_ready k=%0d got %b need %b", k, cfg_ready, want_rdy);
      end
    end
  endtask

  task automatic test_edge_values();
    int t1[$];
    int gap;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk_in);
      if (tick[1]) t1.push_back(k);
      if (k >= 20) begin
        n_tests++;
        if (tick[0] !== 1'b1) begin
          n_fail++; $display("FAIL edge_div0 k=%0d got %b need 1", k, tick[0]);
        end
      end
      n_tests++;
      if (divided_clk !== exp_clk() || tick !== exp_tick()) begin
        n_fail++; $display("FAIL edge_model k=%0d clk=%b tick=%b need clk=%b tick=%b", k, divided_clk, tick, exp_clk(), exp_tick());
      end
      if (k == 1) begin cfg_valid = 1; cfg_ch = 0; cfg_div = 6'd0;  end
      if (k == 2) begin cfg_valid = 1; cfg_ch = 3; cfg_div = 6'd5;  end
      if (k == 3) begin cfg_valid = 1; cfg_ch = 1; cfg_div = 6'd63; end
      if (k == 4) cfg_valid = 0;
      #1;
      if (k <= 3) begin
        n_tests++;
        if (cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL edge_ready k=%0d got %b need 1", k, cfg_ready);
        end
      end
    end
    gap = (t1.size() >= 3) ? (t1[t1.size()-1] - t1[t1.size()-2]) : -1;
    n_tests++;
    if (gap != 64) begin
      n_fail++; $display("FAIL edge_maxdiv half-period got %0d need 64", gap);
    end
  endtask

  task automatic test_reset_mid_pending();
    bit ok;
    ok = 0;
    for (int w = 0; w < 80 && !ok; w++) begin @(negedge clk_in); if (tick[1]) ok = 1; end
    if (!ok) begin n_tests++; n_fail++; $display("FAIL rstp_sync got no tick need tick within 80 cycles"); end
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk_in);
      if (k >= 4 && k <= 6) begin
        n_tests++;
        if (divided_clk !== 2'b00 || tick !== 2'b00 || cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL rstp_inreset k=%0d clk=%b tick=%b ready=%b need 00 00 1", k, divided_clk, tick, cfg_ready);
        end
      end
      if (k >= 7) begin
        n_tests++;
        if (tick !== (((k - 6) % 4 == 0) ? 2'b11 : 2'b00) || cfg_ready !== 1'b1) begin
          n_fail++; $display("FAIL rstp_default k=%0d tick=%b ready=%b need %b 1", k, tick, cfg_ready, ((k - 6) % 4 == 0) ? 2'b11 : 2'b00);
        end
        n_tests++;
        if (divided_clk !== exp_clk() || tick !== exp_tick()) begin
          n_fail++; $display("FAIL rstp_model k=%0d clk=%b tick=%b need clk=%b tick=%b", k, divided_clk, tick, exp_clk(), exp_tick());
        end
      end
      if (k == 1) begin cfg_valid = 1; cfg_ch = 1; cfg_div = 6'd5; end
      if (k == 2) cfg_valid = 0;
      if (k == 6) rst_n = 1;
      #1;
      if (k == 2 || k == 3) begin
        n_tests++;
        if (cfg_ready !== 1'b0) begin
          n_fail++; $display("FAIL rstp_pending k=%0d got %b need 0", k, cfg_ready);
        end
      end
      if (k == 3) begin #1; rst_n = 0; end
    end
  endtask

  task automatic test_random();
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk_in);
      n_tests++;
      if (divided_clk !== exp_clk() || tick !== exp_tick()) begin
        n_fail++; $display("FAIL rand_model k=%0d clk=%b tick=%b need clk=%b tick=%b", k, divided_clk, tick, exp_clk(), exp_tick());
      end
      for (int c = 0; c < N_CH; c++) en[c] = ($urandom_range(0, 4) != 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 3));
      cfg_div   = CNT_W'($urandom_range(0, 7));
      #1;
      n_tests++;
      if (cfg_ready !== exp_ready()) begin
        n_fail++; $display("FAIL rand_ready k=%0d ch=%0d got %b need %b", k, cfg_ch, cfg_ready, exp_ready());
      end
    end
    cfg_valid = 0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_default_run();
    test_reload();
    test_back_to_back();
    test_collision();
    test_enable();
    test_edge_values();
    test_reset_mid_pending();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got still running need finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clk_divider_prog.md
Name: clk_divider_prog

Overview:
Multi-channel, runtime-programmable successor to the fixed-ratio clock divider. It has N_CH independent dividers sharing one input clock. Each channel produces a 50%-duty divided clock and a one-cycle tick strobe. Each channel's divisor can be reloaded at runtime through a valid/ready config port; the new divisor takes effect only at a toggle boundary, so the output never glitches or produces a runt half-period. The block sits beside the board clock to derive slow enables for debouncers, displays, servos and similar consumers.

Parameters:
N_CH, 2, number of independent divider channels (1..8).
CNT_W, 25, counter and divisor width in bits.
DEFAULT_TOGGLE, 1000000, reset value of every channel's active divisor; gives 50 Hz from 100 MHz.
CH_W, 3, width of cfg_ch; must satisfy 2^CH_W >= N_CH.

Ports:
clk_in  input  1  system clock, 100 MHz.
rst_n  input  1  asynchronous, active-low reset.
en  input  N_CH  per-channel run enable.
cfg_valid  input  1  config write request.
cfg_ch  input  CH_W  target channel of the config write.
cfg_div  input  CNT_W  new toggle value for the target channel.
cfg_ready  output  1  config write can be accepted this cycle.
divided_clk  output  N_CH  per-channel divided clock.
tick  output  N_CH  one-cycle pulse in the cycle each channel's divided_clk toggles.

Behaviour:
- Reset (rst_n low, asynchronous; released synchronously to clk_in):
  - all cnt = 0, divided_clk = 0, tick = 0.
  - active_div = DEFAULT_TOGGLE, pending = 0, shadow_div = 0.
  - cfg_ready = 1.
  - Reset asserted mid-count or mid-config aborts everything; nothing pending survives.
- Per channel, en high:
  - If cnt == active_div: terminal count. Next cycle cnt = 0, divided_clk inverts, tick = 1.
  - Otherwise cnt increments and tick = 0.
  - Half-period = active_div+1 cycles; output period = 2*(active_div+1) cycles.
  - active_div = 0 toggles every cycle (clk_in/2).
- Per channel, en low:
  - cnt, divided_clk and active_div hold; tick = 0.
  - If pending = 1: the next cycle loads active_div = shadow_div, clears pending and sets cnt = 0.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational). cfg_ready = 1 whenever cfg_ch >= N_CH.
  - A write is accepted when cfg_valid & cfg_ready. In-range writes set shadow_div[cfg_ch] = cfg_div and pending[cfg_ch] = 1.
  - Out-of-range writes are accepted and discarded.
  - A channel has only one pending slot. While pending is set, cfg_valid for that channel is stalled; nothing is overwritten or dropped.
- Divisor swap:
  - On an enabled terminal count with pending = 1: active_div = shadow_div, pending = 0, and the toggle happens as normal.
  - The half-period in which the swap occurs uses the old divisor. The following half-period uses the new one.
  - A write accepted in the same cycle as that channel's terminal count is not applied at that boundary. It waits for the next terminal count.
- Counter safety:
  - If a counter ever satisfies cnt > active_div, it must wrap via cnt = 0 with a toggle; it must never count to 2^CNT_W.
  - No arithmetic overflow is allowed: cnt is CNT_W bits and compares against CNT_W-bit active_div.
- Channels are fully independent. Simultaneous terminal counts on multiple channels all toggle in the same cycle.
- tick and divided_clk are registered. Zero combinational paths run from inputs to outputs except cfg_ready.

Test Plan:
- Reset default: N_CH=2, DEFAULT_TOGGLE=3, en=2'b11, run 40 cycles -> both divided_clk toggle every 4 cycles (period 8), tick pulses 1 cycle wide coincident with each toggle; all outputs 0 and cfg_ready=1 during rst_n=0.
- Runtime reload: ch0 running div=3; write cfg_ch=0 cfg_div=1 mid half-period -> current half-period finishes at 4 cycles, following half-periods are 2 cycles; cfg_ready low from acceptance until the swap cycle, then high.
- Back-pressure: write ch1 div=5 then immediately write ch1 div=7 -> second write stalls (cfg_ready=0) until the first swap; ch1 sequence is old, 6, then 8-cycle half-periods after the second swap; no write lost.
- Same-cycle collision: accept a write to ch0 exactly on its terminal count -> that boundary keeps the old divisor, and the new value applies at the next boundary.
- Enable/disable: deassert en[1] for 10 cycles with divided_clk[1]=1 -> output holds 1, tick[1]=0, cnt frozen; resumes counting from the held cnt. A pending write while disabled loads next cycle with cnt=0.
- Edge values: cfg_div=0 gives toggle every cycle; cfg_div=2^CNT_W-1 counts without wrap error; cfg_ch=3 (out of range) is accepted with no effect; rst_n pulsed low mid-pending restores DEFAULT_TOGGLE and pending=0.
